// File: rtl/accumulation_controller.sv
// Frame sequencer for the complex accumulator: clears it, gates exactly len
// samples into it, then captures the sum onto a valid/ready result port.
module accumulation_controller #(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int ACC_W   = DATA_W + $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 ce,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 err,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*DATA_W-1:0]  s_data,
  output logic                 acc_clr,
  output logic                 acc_ce,
  output logic [2*DATA_W-1:0]  acc_in,
  input  logic [2*ACC_W-1:0]   acc_val,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*ACC_W-1:0]   m_data
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [2*ACC_W-1:0] m_data_q, m_data_d;
  logic               len_ok;

  assign len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign acc_in = s_data;
  assign m_data = m_data_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    m_data_d = m_data_q;
    busy     = 1'b0;
    err      = 1'b0;
    s_ready  = 1'b0;
    acc_clr  = 1'b0;
    acc_ce   = 1'b0;
    m_valid  = 1'b0;
    if (ce) begin
      busy = (state_q != IDLE);
      // abort outranks everything, including this cycle's handshakes
      if (state_q != IDLE && abort) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                state_d = CLEAR;
                len_d   = len;
              end else begin
                err = 1'b1;
              end
            end
          end
          CLEAR: begin
            acc_clr = 1'b1;
            count_d = '0;
            state_d = ACCUM;
          end
          ACCUM: begin
            s_ready = 1'b1;
            acc_ce  = s_valid;
            if (s_valid) begin
              count_d = count_q + 1'b1;
              if (count_q == len_q - 1'b1) state_d = SETTLE;
            end
          end
          // acc_val reflects the last beat only now, one cycle after it
          SETTLE: begin
            m_data_d = acc_val;
            state_d  = OUTPUT;
          end
          OUTPUT: begin
            m_valid = 1'b1;
            if (m_ready) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      m_data_q <= m_data_d;
    end
  end

endmodule

// File: tb/tb_accumulation_controller.sv
// Directed bench for accumulation_controller with a behavioural accumulator.
module tb_accumulation_controller;
  localparam int DW = 16;
  localparam int ML = 16;
  localparam int LW = $clog2(ML+1);
  localparam int AW = DW + $clog2(ML);

  logic clk = 1'b0, nrst = 1'b0, ce = 1'b1, start = 1'b0, abort = 1'b0;
  logic [LW-1:0] len = '0;
  logic busy, err, s_ready, acc_clr, acc_ce, m_valid;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [2*DW-1:0] s_data = '0, acc_in;
  logic [2*AW-1:0] acc_val, m_data;

  accumulation_controller #(.DATA_W(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .nrst(nrst), .ce(ce), .start(start), .len(len), .abort(abort),
    .busy(busy), .err(err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .acc_clr(acc_clr), .acc_ce(acc_ce), .acc_in(acc_in), .acc_val(acc_val),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // external accumulator: sync clear, add-and-register on acc_ce
  logic signed [AW-1:0] acc_re = '0, acc_im = '0;
  logic signed [DW-1:0] in_re, in_im;
  int pulses = 0, clrs = 0, mv_cnt = 0;
  assign in_re   = acc_in[2*DW-1:DW];
  assign in_im   = acc_in[DW-1:0];
  assign acc_val = {acc_re, acc_im};
  always @(posedge clk) begin
    if (acc_clr) begin acc_re <= '0; acc_im <= '0; end
    else if (acc_ce) begin acc_re <= acc_re + in_re; acc_im <= acc_im + in_im; end
    if (acc_ce)  pulses++;
    if (acc_clr) clrs++;
    if (m_valid) mv_cnt++;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mre();
    return int'($signed(m_data[2*AW-1:AW]));
  endfunction
  function automatic int mim();
    return int'($signed(m_data[AW-1:0]));
  endfunction

  typedef struct {
    int len; int re0; int dre; int im0; int dim;
    int exp_re; int exp_im; bit toggle; int hold; int gap;
  } frame_t;

  typedef struct { bit ce; bit start; int len; bit exp_err; } ivec_t;

  function automatic logic [2*DW-1:0] samp(input frame_t f, input int i);
    logic [DW-1:0] r, m;
    r = DW'(f.re0 + i*f.dre);
    m = DW'(f.im0 + i*f.dim);
    return {r, m};
  endfunction

  task automatic run_frame(input frame_t f);
    int idx, cyc, p0, exp_lat;
    bit got, beat;
    logic [2*AW-1:0] held;
    idx = 0; cyc = 0; got = 0;
    @(negedge clk);
    p0 = pulses;
    start = 1'b1; len = LW'(f.len); s_valid = 1'b1;
    while (!got && cyc < 200) begin
      ce = !(f.gap >= 0 && cyc >= f.gap && cyc < f.gap + 3);
      s_data = samp(f, idx);
      #1;
      if (!ce) chk("ce_gate_outputs", {busy, s_ready, acc_ce, m_valid}, 0);
      if (m_valid) got = 1;
      else begin
        beat = s_valid && s_ready;
        @(posedge clk);
        if (beat) idx++;
        cyc++;
        @(negedge clk);
        start = 1'b0;
        if (f.toggle) s_valid = !s_valid;
      end
    end
    ce = 1'b1;
    exp_lat = f.len + 3 + ((f.gap >= 0) ? 3 : 0);
    if (!f.toggle) chk("latency", cyc, exp_lat);
    else chk("m_valid_seen", got, 1);
    chk("acc_ce_pulses", pulses - p0, f.len);
    chk("m_data_re", mre(), f.exp_re);
    chk("m_data_im", mim(), f.exp_im);
    held = m_data;
    for (int h = 0; h < f.hold; h++) begin
      m_ready = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_data", (m_data == held), 1);
    end
    m_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b0;
    #1 chk("idle_after_ready", busy, 0);
  endtask

  frame_t frames[5];
  ivec_t  ivecs[6];
  frame_t fr;
  int c0, p0, mv0;
  logic [2*AW-1:0] m0;

  initial begin
    frames[0] = '{4, 1, 1, -1, -1, 10, -10, 0, 0, -1};
    frames[1] = '{3, 10, 20, 20, 20, 90, 120, 1, 5, -1};
    frames[2] = '{16, -32768, 0, -32768, 0, -524288, -524288, 0, 0, 4};
    frames[3] = '{3, 100, -50, -7, 0, 150, -21, 0, 1, -1};
    frames[4] = '{16, 32767, 0, 32767, 0, 524272, 524272, 0, 0, -1};
    ivecs[0] = '{1, 1, 0, 1};
    ivecs[1] = '{1, 1, 17, 1};
    ivecs[2] = '{1, 1, 31, 1};
    ivecs[3] = '{1, 0, 4, 0};
    ivecs[4] = '{0, 1, 4, 0};
    ivecs[5] = '{0, 1, 0, 0};

    // reset state
    #12;
    chk("rst_outputs", {busy, err, s_ready, acc_clr, acc_ce, m_valid}, 0);
    chk("rst_m_data", m_data, 0);
    @(negedge clk); nrst = 1'b1;

    // async reset in the middle of ACCUM
    @(negedge clk); start = 1'b1; len = LW'(4); s_valid = 1'b1; s_data = 32'h0001_ffff;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("pre_rst_s_ready", s_ready, 1);
    nrst = 1'b0;
    #1 chk("rst_mid_frame", {busy, s_ready, m_valid}, 0);
    @(negedge clk); nrst = 1'b1; s_valid = 1'b0;
    @(negedge clk); #1 chk("idle_after_rst", busy, 0);

    // illegal len and ce-gated starts in IDLE
    c0 = clrs;
    foreach (ivecs[i]) begin
      @(negedge clk);
      ce = ivecs[i].ce; start = ivecs[i].start; len = LW'(ivecs[i].len);
      #1 chk("err_pulse", err, ivecs[i].exp_err);
      @(negedge clk); ce = 1'b1; start = 1'b0;
      #1 chk("idle_busy", {busy, err}, 0);
    end
    chk("no_acc_clr", clrs - c0, 0);

    foreach (frames[i]) run_frame(frames[i]);

    // abort after 2 of 8 beats
    @(negedge clk);
    m0 = m_data; mv0 = mv_cnt; p0 = pulses;
    start = 1'b1; len = LW'(8); s_valid = 1'b1; s_data = {16'd100, 16'd100};
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    abort = 1'b1;
    #1 chk("abort_cycle_outputs", {s_ready, acc_ce, m_valid}, 0);
    @(negedge clk); abort = 1'b0; s_valid = 1'b0;
    #1 chk("abort_idle", busy, 0);
    chk("abort_beats", pulses - p0, 2);
    chk("abort_no_m_valid", mv_cnt - mv0, 0);
    chk("abort_m_data_kept", (m_data == m0), 1);
    fr = '{1, 5, 0, 7, 0, 5, 7, 0, 0, -1};
    run_frame(fr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
